// File: rtl/fwd_pkg.sv
// Shared types and constants for the forwarding scoreboard.
// Slot records keep rd zero-extended to FWD_AW_MAX bits so one packed type
// serves every AW up to that width.
package fwd_pkg;

  localparam int unsigned FWD_AW_DEFAULT    = 5;
  localparam int unsigned FWD_DEPTH_DEFAULT = 2;
  localparam int unsigned FWD_AW_MAX        = 8;
  localparam int unsigned FWD_SEL_RF        = 0;

  typedef struct packed {
    logic                  wr;
    logic                  ld;
    logic [FWD_AW_MAX-1:0] rd;
  } fwd_slot_t;

  // Build a slot record; register 0 is never marked as written.
  function automatic fwd_slot_t fwd_capture(input logic                  valid,
                                            input logic                  regwrite,
                                            input logic                  is_load,
                                            input logic [FWD_AW_MAX-1:0] rd);
    fwd_slot_t s;
    s.wr = valid & regwrite & (rd != '0);
    s.ld = is_load;
    s.rd = rd;
    return s;
  endfunction

endpackage

// File: rtl/fwd_prio_match.sv
// Priority match of one source register against a vector of slots.
// Element 0 is the youngest slot; the youngest matching writer wins.
// The reported select is the element index plus BASE.
module fwd_prio_match
  import fwd_pkg::*;
#(
  parameter int unsigned AW    = FWD_AW_DEFAULT,
  parameter int unsigned NSLOT = FWD_DEPTH_DEFAULT,
  parameter int unsigned BASE  = 1,
  parameter int unsigned SW    = 2
) (
  input  logic                  [AW-1:0] i_src,
  input  fwd_slot_t [NSLOT-1:0]          i_slots,
  output logic                           o_match,
  output logic                  [SW-1:0] o_sel,
  output logic                           o_is_load
);

  logic [FWD_AW_MAX-1:0] w_src;

  assign w_src = FWD_AW_MAX'(i_src);

  // Scan oldest to youngest so the youngest match overwrites older ones.
  always_comb begin
    o_match   = 1'b0;
    o_sel     = SW'(FWD_SEL_RF);
    o_is_load = 1'b0;
    for (int i = NSLOT - 1; i >= 0; i--) begin
      if (i_slots[i].wr && (i_slots[i].rd == w_src)) begin
        o_match   = 1'b1;
        o_sel     = SW'(i + BASE);
        o_is_load = i_slots[i].ld;
      end
    end
  end

endmodule

// File: rtl/fwd_scoreboard.sv
// Forwarding scoreboard: tracks destination tags of the DEPTH instructions
// past EX, drives per-operand forward selects for EX and raises a load-use
// stall for ID.
// Optional statistics counters: define FWD_SCOREBOARD_STATS_EN.
module fwd_scoreboard
  import fwd_pkg::*;
#(
  parameter int unsigned AW              = FWD_AW_DEFAULT,
  parameter int unsigned NSRC            = 2,
  parameter int unsigned DEPTH           = FWD_DEPTH_DEFAULT,
  parameter int unsigned LOAD_READY_SLOT = 2,
  parameter int unsigned SW              = $clog2(DEPTH + 1)
) (
  input  logic               clk_i,
  input  logic               rst_i,
  input  logic               ex_valid_i,
  input  logic               ex_regwrite_i,
  input  logic               ex_is_load_i,
  input  logic [AW-1:0]      ex_rd_i,
  input  logic [NSRC*AW-1:0] ex_src_i,
  input  logic [NSRC*AW-1:0] id_src_i,
  input  logic [NSRC-1:0]    id_src_used_i,
  output logic [NSRC*SW-1:0] forward_sel_o,
  output logic               stall_o,
  output logic [31:0]        stall_cnt_o,
  output logic [31:0]        fwd_cnt_o
);

  // r_slot[i] holds slot i+1 (EX/MEM is r_slot[0]).
  fwd_slot_t [DEPTH-1:0] r_slot;
  fwd_slot_t             w_ex_slot;
  fwd_slot_t [DEPTH:0]   w_id_slots;
  logic                  r_post_rst;

  logic [SW-1:0]   w_ex_sel [NSRC];
  logic [NSRC-1:0] w_ex_match;
  logic [NSRC-1:0] w_ex_ld;
  logic [SW-1:0]   w_id_sel [NSRC];
  logic [NSRC-1:0] w_id_match;
  logic [NSRC-1:0] w_id_ld;
  logic [NSRC-1:0] w_id_hazard;
  logic            w_unused_ex;

  assign w_ex_slot  = fwd_capture(ex_valid_i, ex_regwrite_i, ex_is_load_i, FWD_AW_MAX'(ex_rd_i));
  // The instruction in EX acts as virtual slot 0 for the ID lookup.
  assign w_id_slots = {r_slot, w_ex_slot};

  // Shift the tag pipeline every cycle; bubbles arrive as ex_valid_i = 0.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_slot <= '0;
    end else begin
      r_slot[0] <= w_ex_slot;
      for (int k = 1; k < int'(DEPTH); k++) begin
        r_slot[k] <= r_slot[k-1];
      end
    end
  end

  // Marks the first cycle after reset release, when stall must stay low.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_post_rst <= 1'b1;
    end else begin
      r_post_rst <= 1'b0;
    end
  end

  for (genvar n = 0; n < NSRC; n++) begin : g_src
    fwd_prio_match #(
      .AW   (AW),
      .NSLOT(DEPTH),
      .BASE (1),
      .SW   (SW)
    ) u_ex_match (
      .i_src    (ex_src_i[n*AW +: AW]),
      .i_slots  (r_slot),
      .o_match  (w_ex_match[n]),
      .o_sel    (w_ex_sel[n]),
      .o_is_load(w_ex_ld[n])
    );

    fwd_prio_match #(
      .AW   (AW),
      .NSLOT(DEPTH + 1),
      .BASE (0),
      .SW   (SW)
    ) u_id_match (
      .i_src    (id_src_i[n*AW +: AW]),
      .i_slots  (w_id_slots),
      .o_match  (w_id_match[n]),
      .o_sel    (w_id_sel[n]),
      .o_is_load(w_id_ld[n])
    );

    assign forward_sel_o[n*SW +: SW] = w_ex_sel[n];

    // Youngest writer at virtual slot j is a load still short of the ready slot.
    assign w_id_hazard[n] = id_src_used_i[n] & w_id_match[n] & w_id_ld[n] &
                            ((32'(w_id_sel[n]) + 32'd1) < LOAD_READY_SLOT);
  end

  // A forward from a not-yet-ready load is still reported as its slot number.
  assign w_unused_ex = ^{w_ex_match, w_ex_ld};

  assign stall_o = (|w_id_hazard) & ~rst_i & ~r_post_rst;

`ifdef FWD_SCOREBOARD_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_fwd_cnt;
  logic [31:0] w_fwd_inc;

  // Number of valid EX operands taking a forwarded value this cycle.
  always_comb begin
    w_fwd_inc = '0;
    for (int i = 0; i < int'(NSRC); i++) begin
      w_fwd_inc = w_fwd_inc + 32'(ex_valid_i & w_ex_match[i]);
    end
  end

  // Free-running statistics, wrapping modulo 2^32.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stall_cnt <= '0;
      r_fwd_cnt   <= '0;
    end else begin
      r_stall_cnt <= r_stall_cnt + 32'(stall_o);
      r_fwd_cnt   <= r_fwd_cnt + w_fwd_inc;
    end
  end

  assign stall_cnt_o = r_stall_cnt;
  assign fwd_cnt_o   = r_fwd_cnt;
`else
  assign stall_cnt_o = '0;
  assign fwd_cnt_o   = '0;
`endif

endmodule

// File: doc/fwd_scoreboard.md
Name: fwd_scoreboard

Overview:
- Parametrised successor to the two-stage forwarding unit.
- Holds an internal shift pipeline of destination tags for instructions past EX, so EX/MEM and MEM/WB RD/regwrite no longer need to be routed in.
- Drives a per-source forward select for NSRC operands over DEPTH stages.
- Detects load-use hazards for the instruction in ID and raises a stall.

Parameters:
- AW, 5: register address width.
- NSRC, 2: source operands per instruction (RS, RT, ...).
- DEPTH, 2: tracked slots past EX. Slot 1 = EX/MEM, slot DEPTH = oldest.
- LOAD_READY_SLOT, 2: first slot whose load result may be forwarded; 1 ≤ LOAD_READY_SLOT ≤ DEPTH.
- SW, $clog2(DEPTH+1): width of one forward select.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  asynchronous reset, active-high
- ex_valid_i  in  1  EX holds a real instruction (0 = bubble)
- ex_regwrite_i  in  1  EX instruction writes a register
- ex_is_load_i  in  1  EX instruction is a load
- ex_rd_i  in  AW  EX destination register
- ex_src_i  in  NSRC*AW  EX source registers; operand n occupies bits [n*AW +: AW]
- id_src_i  in  NSRC*AW  ID source registers
- id_src_used_i  in  NSRC  ID operand n is actually read
- forward_sel_o  out  NSRC*SW  per EX operand: 0 = register file, k = slot k
- stall_o  out  1  load-use stall request for ID
- stall_cnt_o  out  32  stall-cycle count (see optional feature)
- fwd_cnt_o  out  32  forwarded-operand count (see optional feature)

Behaviour:
- Slot state per entry: wr (1), rd (AW), ld (1).
- Every clock edge:
  - slot[1] <= {ex_valid_i & ex_regwrite_i & (ex_rd_i != 0), ex_rd_i, ex_is_load_i}.
  - slot[k] <= slot[k-1] for k = 2..DEPTH.
  - The oldest entry is discarded.
  - No enable: the pipeline front-end signals bubbles via ex_valid_i = 0.
- Reset (rst_i = 1, asynchronous, any time, including mid-stream):
  - All wr, ld and rd clear to 0.
  - forward_sel_o = 0 and stall_o = 0 while asserted and on the first cycle after release.
  - Counters clear to 0.
- forward_sel, combinational from slot state and ex_src_i:
  - Operand n selects the smallest k with slot[k].wr and slot[k].rd == src_n.
  - No match → 0.
  - Register 0 never matches, because wr is forced 0 on capture.
  - Youngest-wins replaces the old fixed MEM-over-WB priority and holds for any DEPTH.
- Load-use stall, combinational from slot state, the current EX inputs and the ID inputs:
  - Treat EX as virtual slot 0.
  - For each used ID operand, find the youngest writer j in 0..DEPTH with matching rd.
  - Stall if that writer is a load and j+1 < LOAD_READY_SLOT.
  - A younger non-load writer to the same rd shadows an older load: no stall.
- Stall protocol: the pipeline is expected to inject a bubble (ex_valid_i = 0) while stall_o = 1. The block keeps shifting; stall_o falls once the load has advanced far enough.
- Protocol violation: a forward_sel pointing at a load slot k < LOAD_READY_SLOT is a pipeline bug. The block still reports k; the bench flags it.
- Multiple operands matching different slots resolve independently. The same rd in two slots resolves to the younger slot.

Optional Feature:
- FWD_SCOREBOARD_STATS_EN defined:
  - stall_cnt_o increments on every cycle with stall_o = 1.
  - fwd_cnt_o adds the number of operands with a nonzero select whose EX instruction is valid.
  - Both wrap modulo 2^32 and clear on reset.
- Not defined: no counter flops; both ports tied to 0.

Decomposition:
- Package fwd_pkg: slot typedef {wr, ld, rd}, constant FWD_SEL_RF = 0, default AW/DEPTH constants.
- One sub-module, fwd_prio_match: an NSRC-independent priority encoder taking one source address plus the slot vector, returning select and matched-is-load. Instantiated NSRC times for EX and NSRC times for ID (ID instances include virtual slot 0).

Test Plan:
- Reset mid-stream: slots loaded with rd = 3, then rst_i pulsed → forward_sel_o = 0 and stall_o = 0 immediately (asynchronous), and on the cycle after release.
- Back-to-back ALU: add r3 in EX; next cycle EX src0 = 3 → sel0 = 1; one cycle later (intervening bubble) → sel0 = 2; third cycle → 0.
- Youngest wins: r5 written at slots 1 and 2, src0 = src1 = 5 → both selects = 1. r0 write with src = 0 → select 0.
- Load-use, LOAD_READY_SLOT = 2: lw r7 in EX, ID src1 = 7 and used → stall_o = 1 for one cycle. With a bubble inserted, the next cycle gives stall_o = 0 and EX sel1 = 2. With used = 0 → no stall.
- Shadowing and generality, DEPTH = 4, LOAD_READY_SLOT = 3: lw r9 at slot 1, add r9 in EX, ID reads r9 → stall_o = 0. Without the add → stall_o = 1 for one cycle.
- With FWD_SCOREBOARD_STATS_EN: 3 stall cycles and 5 forwarded operands → stall_cnt_o = 3, fwd_cnt_o = 5. Without the macro, both read 0.
